// File: rtl/pattern_frame_writer.sv
// Test-pattern frame writer: fills a 2^IMG_W_LOG2 x 2^IMG_H_LOG2 frame in SRAM,
// one word per pixel, through an acknowledged write handshake.
module pattern_frame_writer #(
    parameter int IMG_W_LOG2 = 5,
    parameter int IMG_H_LOG2 = 5,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32,
    parameter int CHECK_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [23:0]       solid_color,
    input  logic [ADDR_W-1:0] starting_address,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done
);
    localparam int PIX_W = IMG_W_LOG2 + IMG_H_LOG2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [IMG_W_LOG2-1:0] x;
    logic [IMG_H_LOG2-1:0] y;
    logic [PIX_W-1:0]      idx;
    logic [2:0]            mode_q;
    logic [23:0]           color_q;
    logic [ADDR_W-1:0]     base_q;
    logic [23:0]           next_pix;

    // Left-align a coordinate into 8 bits: (v << 8) >> bits covers both
    // narrow (v << (8-bits)) and wide (top 8 bits of v) coordinates.
    function automatic logic [7:0] gray(input logic [9:0] v, input int bits);
        logic [17:0] t;
        t = {8'd0, v} << 8;
        t = t >> bits;
        return t[7:0];
    endfunction

    function automatic logic [23:0] pixel(input logic [2:0]            m,
                                          input logic [23:0]           solid,
                                          input logic [IMG_W_LOG2-1:0] px,
                                          input logic [IMG_H_LOG2-1:0] py);
        logic [2:0]  b;
        logic [7:0]  lvl;
        logic [23:0] c;
        b   = px[IMG_W_LOG2-1 -: 3];
        lvl = 8'd0;
        c   = solid;
        case (m)
            3'd1: begin
                case (b)
                    3'd0:    c = 24'hc0c0c0;
                    3'd1:    c = 24'hc0c000;
                    3'd2:    c = 24'h00c0c0;
                    3'd3:    c = 24'h00c000;
                    3'd4:    c = 24'hc000c0;
                    3'd5:    c = 24'hc00000;
                    3'd6:    c = 24'h0000c0;
                    default: c = 24'hffffff;
                endcase
            end
            3'd2:    c = (px[CHECK_LOG2] ^ py[CHECK_LOG2]) ? 24'h000000 : 24'hffffff;
            3'd3: begin
                lvl = gray(10'(px), IMG_W_LOG2);
                c   = {lvl, lvl, lvl};
            end
            3'd4: begin
                lvl = gray(10'(py), IMG_H_LOG2);
                c   = {lvl, lvl, lvl};
            end
            default: c = solid;
        endcase
        return c;
    endfunction

    // The first pixel is launched straight from IDLE, before the latched
    // copies of mode/colour exist, so it uses the live inputs at (0,0).
    always_comb begin
        next_pix = pixel(mode_q, color_q, x, y);
        if (state == S_IDLE) begin
            next_pix = pixel(mode, solid_color, '0, '0);
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            mode_q  <= mode;
            color_q <= solid_color;
            base_q  <= starting_address;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            idx      <= '0;
            mem_data <= '0;
            mem_addr <= '0;
            mem_wren <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_data <= '0;
                    mem_addr <= '0;
                    mem_wren <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    if (start) begin
                        x        <= '0;
                        y        <= '0;
                        idx      <= '0;
                        state    <= S_WRITE;
                        mem_wren <= 1'b1;
                        mem_addr <= starting_address;
                        mem_data <= DATA_W'(next_pix);
                        busy     <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_wren <= 1'b0;
                        mem_addr <= '0;
                        mem_data <= '0;
                        if (idx == '1) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            x     <= x + 1'b1;
                            if (x == '1) y <= y + 1'b1;
                            idx   <= idx + 1'b1;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    state    <= S_WRITE;
                    mem_wren <= 1'b1;
                    mem_addr <= base_q + ADDR_W'(idx);
                    mem_data <= DATA_W'(next_pix);
                end
                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_frame_writer.sv
// Randomized bench for pattern_frame_writer: every accepted write is compared
// against a pixel-index based model of the frame contents.
module tb_pattern_frame_writer;
    localparam int WL = 5, HL = 5, AW = 18, DW = 32, CL = 2;
    localparam int W = 1 << WL, H = 1 << HL, P = W * H;
    localparam int LIMIT = 8 * P + 100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [23:0]   solid_color = 24'd0;
    logic [AW-1:0] starting_address = '0;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_wren;
    logic          mem_ack = 1'b0;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pattern_frame_writer #(
        .IMG_W_LOG2(WL), .IMG_H_LOG2(HL), .ADDR_W(AW), .DATA_W(DW), .CHECK_LOG2(CL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .solid_color(solid_color), .starting_address(starting_address),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_wren(mem_wren),
        .mem_ack(mem_ack), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame contents from pixel index k in raster order.
    function automatic logic [23:0] ref_pix(input int k, input logic [2:0] m, input logic [23:0] c);
        int x, y, lv;
        x = k % W;
        y = k / W;
        case (m)
            3'd1: begin
                case ((x * 8) / W)
                    0: return 24'hc0c0c0;
                    1: return 24'hc0c000;
                    2: return 24'h00c0c0;
                    3: return 24'h00c000;
                    4: return 24'hc000c0;
                    5: return 24'hc00000;
                    6: return 24'h0000c0;
                    default: return 24'hffffff;
                endcase
            end
            3'd2: return ((((x >> CL) + (y >> CL)) % 2) == 0) ? 24'hffffff : 24'h000000;
            3'd3: begin lv = (x * 256) / W; return {3{8'(lv)}}; end
            3'd4: begin lv = (y * 256) / H; return {3{8'(lv)}}; end
            default: return c;
        endcase
    endfunction

    task automatic run_frame(input logic [2:0] m, input logic [23:0] c, input logic [AW-1:0] base,
                             input bit stall, input int abort_at, input bit hold);
        int k = 0, cyc = 0, stall_left = 0, done_cyc = -1;
        bit seen = 0, prev_stall = 0, prev_acc = 0;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pdata;
        logic [AW-1:0] ea;
        @(negedge clk);
        check("idle_before", {busy, done, mem_wren}, 0);
        start = 1'b1; mode = m; solid_color = c; starting_address = base;
        mem_ack = 1'($urandom);
        while (cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("first_wren_latency", mem_wren, 1);
                start = hold;
            end
            // latched inputs must be ignored once the frame has begun
            mode = 3'($urandom);
            solid_color = 24'($urandom);
            starting_address = AW'($urandom);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (prev_stall) begin
                check("stall_wren", mem_wren, 1);
                check("stall_addr", mem_addr, paddr);
                check("stall_data", mem_data, pdata);
            end
            if (prev_acc) check("gap_wren", mem_wren, 0);
            prev_stall = 0;
            prev_acc = 0;
            if (mem_wren) begin
                if (!seen) begin
                    ea = base + AW'(k);
                    check($sformatf("addr_px%0d", k), mem_addr, ea);
                    check($sformatf("data_px%0d", k), mem_data, DW'(ref_pix(k, m, c)));
                    seen = 1;
                    stall_left = stall ? $urandom_range(0, 5) : 0;
                end
                if (k == abort_at) begin
                    reset = 1'b1;
                    mem_ack = 1'b0;
                    @(negedge clk);
                    check("abort_outputs", {mem_data, mem_addr, mem_wren, busy, done}, 0);
                    reset = 1'b0;
                    start = 1'b0;
                    return;
                end
                if (stall_left == 0) begin
                    mem_ack = 1'b1;
                    prev_acc = 1;
                    k++;
                    seen = 0;
                end else begin
                    mem_ack = 1'b0;
                    stall_left--;
                    prev_stall = 1;
                    paddr = mem_addr;
                    pdata = mem_data;
                end
            end else begin
                mem_ack = 1'($urandom);
            end
        end
        check("done_seen", done_cyc > 0, 1);
        check("accepted_writes", k, P);
        if (!stall) check("done_latency", done_cyc, 2 * P);
        check("done_outputs", {mem_data, mem_addr, mem_wren, busy}, 0);
        if (hold) begin
            repeat (4) begin
                @(negedge clk);
                check("hold_done", {done, busy, mem_wren}, 3'b100);
            end
            start = 1'b0;
        end
        @(negedge clk);
        check("back_to_idle", {done, busy, mem_wren}, 0);
        mem_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {mem_data, mem_addr, mem_wren, busy, done}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {mem_data, mem_addr, mem_wren, busy, done}, 0);
        run_frame(3'd1, 24'h000000, 18'h00100, 0, -1, 0);
        run_frame(3'd2, 24'($urandom), AW'($urandom), 0, -1, 0);
        run_frame(3'd3, 24'($urandom), AW'($urandom), 0, -1, 0);
        run_frame(3'd4, 24'($urandom), AW'($urandom), 1, -1, 0);
        run_frame(3'd0, 24'h123456, 18'h3FFF0, 1, -1, 0);
        run_frame(3'd1, 24'd0, 18'h01000, 0, 300, 0);
        run_frame(3'd2, 24'd0, 18'h20000, 1, -1, 0);
        run_frame(3'd6, 24'habcdef, 18'h3FC00, 0, -1, 1);
        run_frame(3'd7, 24'($urandom), AW'($urandom), 1, -1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
